// File: rtl/tone_divider_prog_pkg.sv
// Shared definitions for the musical-notes path: duty codes, the duty threshold
// helper and divisors for common notes at a 100 MHz system clock.
package tone_divider_prog_pkg;

    localparam int DEFAULT_MIN_DIV = 2;

    localparam logic [1:0] DUTY_50 = 2'b00;
    localparam logic [1:0] DUTY_25 = 2'b01;
    localparam logic [1:0] DUTY_12 = 2'b10;
    localparam logic [1:0] DUTY_75 = 2'b11;

    // The threshold helper works at this width; callers cast in and out so any
    // counter width up to 64 bits can use it without overflow.
    localparam int THRESH_W = 64;

    // Divisors (clock cycles per period) for notes at 100 MHz.
    localparam int NOTE_C4 = 382226;
    localparam int NOTE_D4 = 340530;
    localparam int NOTE_E4 = 303370;
    localparam int NOTE_F4 = 286345;
    localparam int NOTE_G4 = 255102;
    localparam int NOTE_A4 = 227273;
    localparam int NOTE_B4 = 202478;
    localparam int NOTE_C5 = 191113;

    // Number of high cycles at the start of a period of d cycles.
    function automatic logic [THRESH_W-1:0] duty_thresh(
        input logic [THRESH_W-1:0] d,
        input logic [1:0]          duty
    );
        logic [THRESH_W-1:0] t;
        case (duty)
            DUTY_25: t = d >> 2;
            DUTY_12: t = d >> 3;
            DUTY_75: t = d - (d >> 2);
            default: t = d >> 1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tone_divider_prog.sv
// Programmable square-wave tone generator. Divisor/duty loads are staged in a
// shadow register and applied only at period boundaries (or at once when idle).
module tone_divider_prog
    import tone_divider_prog_pkg::*;
#(
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 200000,
    parameter int MIN_DIV     = DEFAULT_MIN_DIV
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_value,
    input  logic [1:0]       duty_sel,
    input  logic             div_load,
    output logic             h,
    output logic             period_tick,
    output logic             pending,
    output logic [CNT_W-1:0] active_div
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV_C = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [CNT_W-1:0] counter;
    logic [1:0]       active_duty;
    logic [CNT_W-1:0] shadow_div;
    logic [1:0]       shadow_duty;

    logic [CNT_W-1:0] load_div;
    logic [CNT_W-1:0] next_div;
    logic [1:0]       next_duty;
    logic [CNT_W-1:0] thresh;
    logic             running;
    logic             wrap;
    logic             apply;

    always_comb begin
        load_div  = div_value;
        next_div  = shadow_div;
        next_duty = shadow_duty;
        running   = 1'b0;
        wrap      = 1'b0;
        apply     = 1'b0;
        thresh    = '0;

        // Zero means mute and is kept; other too-small divisors are raised.
        if (div_value != '0 && div_value < MIN_DIV_C)
            load_div = MIN_DIV_C;

        running = enable && (active_div != '0);
        wrap    = running && (counter == active_div - ONE_C);

        // A load in this very cycle bypasses the shadow so it can apply now.
        if (div_load) begin
            next_div  = load_div;
            next_duty = duty_sel;
        end

        // Boundaries are a wrap while running, or any cycle while idle.
        apply  = (wrap || !running) && (pending || div_load);
        thresh = CNT_W'(duty_thresh(THRESH_W'(active_div), active_duty));
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            active_div  <= DEF_DIV_C;
            active_duty <= DUTY_50;
            shadow_div  <= DEF_DIV_C;
            shadow_duty <= DUTY_50;
            pending     <= 1'b0;
            h           <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            h           <= running && (counter < thresh);
            period_tick <= wrap;

            if (running && !wrap)
                counter <= counter + ONE_C;
            else
                counter <= '0;

            if (div_load) begin
                shadow_div  <= load_div;
                shadow_duty <= duty_sel;
            end

            if (apply) begin
                active_div  <= next_div;
                active_duty <= next_duty;
                pending     <= 1'b0;
            end else if (div_load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
